// File: rtl/fmr_fault_injector.sv
// Five-lane replicator for the 5MR datapath with a programmable single-lane
// fault injector (stuck-at-0/1 or invert over a delayed window of valid samples).
module fmr_fault_injector #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_in,
  input  logic             d_valid,
  output logic [4:0]       lane_out,
  output logic             lane_valid,
  output logic [4:0]       fault_mask,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_lane,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             cfg_abort,
  output logic             busy,
  output logic             cfg_err,
  output logic [7:0]       inj_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [2:0]       lane_q, lane_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             perm_q, perm_d;
  logic             first_q, first_d;
  logic [4:0]       lane_out_q, lane_out_d;
  logic             lane_valid_q, lane_valid_d;
  logic [4:0]       fault_mask_q, fault_mask_d;
  logic             cfg_err_q, cfg_err_d;
  logic [7:0]       inj_count_q, inj_count_d;

  logic             accept_s;
  logic             illegal_s;
  logic             corrupt_s;
  logic [4:0]       sel_s;

  function automatic logic corrupt_bit(input logic [1:0] mode, input logic d);
    logic r;
    case (mode)
      2'b00:   r = 1'b0;
      2'b01:   r = 1'b1;
      2'b10:   r = ~d;
      default: r = d;
    endcase
    return r;
  endfunction

  // Next-state, sample counters and the registered lane outputs.
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    perm_d       = perm_q;
    first_d      = first_q;
    inj_count_d  = inj_count_q;
    accept_s     = cfg_valid && (state_q == IDLE);
    illegal_s    = (cfg_lane > 3'd4) || (cfg_mode == 2'b11);
    corrupt_s    = (state_q == ACTIVE) && d_valid && !cfg_abort;
    cfg_err_d    = accept_s && illegal_s;
    lane_valid_d = d_valid;
    sel_s        = 5'b00001 << lane_q;
    fault_mask_d = 5'b00000;
    lane_out_d   = d_valid ? {5{d_in}} : lane_out_q;

    case (state_q)
      IDLE: begin
        if (accept_s && !illegal_s) begin
          lane_d  = cfg_lane;
          mode_d  = cfg_mode;
          len_d   = cfg_len;
          perm_d  = (cfg_len == '0);
          first_d = 1'b1;
          if (cfg_delay != '0) begin
            state_d = ARMED;
            cnt_d   = cfg_delay;
          end else begin
            state_d = ACTIVE;
            cnt_d   = cfg_len;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (d_valid) begin
          // cnt holds clean samples still to pass; the last one hands over to len.
          if (cnt_q == CNT_ONE) begin
            state_d = ACTIVE;
            cnt_d   = len_q;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          state_d = ARMED;
        end
      end
      ACTIVE: begin
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (d_valid) begin
          first_d = 1'b0;
          if (first_q && (inj_count_q != 8'd255)) begin
            inj_count_d = inj_count_q + 8'd1;
          end else begin
            inj_count_d = inj_count_q;
          end
          if (perm_q) begin
            state_d = ACTIVE;
          end else if (cnt_q == CNT_ONE) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          state_d = ACTIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (corrupt_s) begin
      lane_out_d   = ({5{d_in}} & ~sel_s) | ({5{corrupt_bit(mode_q, d_in)}} & sel_s);
      fault_mask_d = sel_s;
    end else begin
      fault_mask_d = 5'b00000;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lane_q       <= 3'd0;
      mode_q       <= 2'd0;
      cnt_q        <= '0;
      len_q        <= '0;
      perm_q       <= 1'b0;
      first_q      <= 1'b0;
      lane_out_q   <= 5'b00000;
      lane_valid_q <= 1'b0;
      fault_mask_q <= 5'b00000;
      cfg_err_q    <= 1'b0;
      inj_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      perm_q       <= perm_d;
      first_q      <= first_d;
      lane_out_q   <= lane_out_d;
      lane_valid_q <= lane_valid_d;
      fault_mask_q <= fault_mask_d;
      cfg_err_q    <= cfg_err_d;
      inj_count_q  <= inj_count_d;
    end
  end

  assign lane_out   = lane_out_q;
  assign lane_valid = lane_valid_q;
  assign fault_mask = fault_mask_q;
  assign cfg_err    = cfg_err_q;
  assign inj_count  = inj_count_q;
  assign cfg_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fmr_fault_injector.sv
// Directed self-checking bench for fmr_fault_injector.
module tb_fmr_fault_injector;

  logic       clk;
  logic       rst_n;
  logic       d_in;
  logic       d_valid;
  logic [4:0] lane_out;
  logic       lane_valid;
  logic [4:0] fault_mask;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_lane;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_delay;
  logic [7:0] cfg_len;
  logic       cfg_abort;
  logic       busy;
  logic       cfg_err;
  logic [7:0] inj_count;

  int checks;
  int errors;
  int exp_inj;

  fmr_fault_injector #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_valid(d_valid),
    .lane_out(lane_out), .lane_valid(lane_valid), .fault_mask(fault_mask),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_lane(cfg_lane),
    .cfg_mode(cfg_mode), .cfg_delay(cfg_delay), .cfg_len(cfg_len),
    .cfg_abort(cfg_abort), .busy(busy), .cfg_err(cfg_err), .inj_count(inj_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic d);
    d_valid = 1'b1;
    d_in    = d;
    step();
    d_valid = 1'b0;
  endtask

  task automatic cmd(input logic [2:0] lane, input logic [1:0] mode,
                     input logic [7:0] delay, input logic [7:0] len);
    cfg_valid = 1'b1;
    cfg_lane  = lane;
    cfg_mode  = mode;
    cfg_delay = delay;
    cfg_len   = len;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (lane_out !== 5'b00000) begin errors++; $display("FAIL reset_lane_out got %b exp 00000", lane_out); end
    checks++; if (lane_valid !== 1'b0) begin errors++; $display("FAIL reset_lane_valid got %b exp 0", lane_valid); end
    checks++; if (fault_mask !== 5'b00000) begin errors++; $display("FAIL reset_mask got %b exp 00000", fault_mask); end
    checks++; if (busy !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL reset_busy_err got %b%b exp 00", busy, cfg_err); end
    checks++; if (inj_count !== 8'd0) begin errors++; $display("FAIL reset_inj got %0d exp 0", inj_count); end
    step(); step();
    rst_n = 1'b1;
    step();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cfg_ready); end
  endtask

  task automatic test_clean();
    logic [2:0] pat;
    pat = 3'b101;
    for (int i = 0; i < 3; i++) begin
      sample(pat[2-i]);
      checks++; if (lane_out !== {5{pat[2-i]}} || lane_valid !== 1'b1) begin errors++; $display("FAIL clean_lane_out[%0d] got %b/%b exp %b/1", i, lane_out, lane_valid, {5{pat[2-i]}}); end
      checks++; if (fault_mask !== 5'b00000 || busy !== 1'b0) begin errors++; $display("FAIL clean_mask_busy[%0d] got %b/%b exp 00000/0", i, fault_mask, busy); end
    end
    d_in = 1'b0;
    step();
    checks++; if (lane_out !== 5'b11111 || lane_valid !== 1'b0) begin errors++; $display("FAIL clean_hold got %b/%b exp 11111/0", lane_out, lane_valid); end
  endtask

  task automatic test_window();
    logic [4:0] exp_lo [6];
    logic [4:0] exp_fm [6];
    exp_lo = '{5'b11111, 5'b11111, 5'b11111, 5'b11011, 5'b11011, 5'b11111};
    exp_fm = '{5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00100, 5'b00000};
    cmd(3'd2, 2'b10, 8'd3, 8'd2);
    checks++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin errors++; $display("FAIL window_armed got busy=%b ready=%b exp 1/0", busy, cfg_ready); end
    for (int i = 0; i < 6; i++) begin
      sample(1'b1);
      checks++; if (lane_out !== exp_lo[i] || fault_mask !== exp_fm[i]) begin errors++; $display("FAIL window_sample[%0d] got %b/%b exp %b/%b", i, lane_out, fault_mask, exp_lo[i], exp_fm[i]); end
      if (i == 4) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL window_idle got busy=%b exp 0", busy); end
      end
    end
    exp_inj = 1;
    checks++; if (inj_count !== 8'(exp_inj)) begin errors++; $display("FAIL window_inj got %0d exp %0d", inj_count, exp_inj); end
  endtask

  task automatic test_gaps();
    cmd(3'd0, 2'b00, 8'd0, 8'd2);
    for (int i = 0; i < 4; i++) begin
      d_valid = (i % 2 == 0);
      d_in    = 1'b1;
      step();
      checks++; if (lane_out !== 5'b11110 || lane_valid !== d_valid || fault_mask !== (d_valid ? 5'b00001 : 5'b00000)) begin errors++; $display("FAIL gaps_cycle[%0d] got %b/%b/%b exp 11110/%b", i, lane_out, lane_valid, fault_mask, d_valid); end
    end
    d_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gaps_done got busy=%b exp 0", busy); end
    sample(1'b1);
    checks++; if (lane_out !== 5'b11111) begin errors++; $display("FAIL gaps_after got %b exp 11111", lane_out); end
    exp_inj = 2;
    checks++; if (inj_count !== 8'(exp_inj)) begin errors++; $display("FAIL gaps_inj got %0d exp %0d", inj_count, exp_inj); end
  endtask

  task automatic test_perm_abort();
    int bad;
    bad = 0;
    cmd(3'd4, 2'b01, 8'd0, 8'd0);
    for (int i = 0; i < 300; i++) begin
      sample(1'b0);
      checks++; if (lane_out !== 5'b10000 || fault_mask !== 5'b10000) begin errors++; bad++; if (bad < 4) $display("FAIL perm_sample[%0d] got %b/%b exp 10000/10000", i, lane_out, fault_mask); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL perm_busy got %b exp 1", busy); end
    cfg_abort = 1'b1;
    sample(1'b0);
    cfg_abort = 1'b0;
    checks++; if (lane_out !== 5'b00000 || fault_mask !== 5'b00000) begin errors++; $display("FAIL abort_sample got %b/%b exp 00000/00000", lane_out, fault_mask); end
    checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_idle got busy=%b ready=%b exp 0/1", busy, cfg_ready); end
    exp_inj = 3;
    checks++; if (inj_count !== 8'(exp_inj)) begin errors++; $display("FAIL perm_inj got %0d exp %0d", inj_count, exp_inj); end
  endtask

  task automatic test_idle_abort();
    cfg_abort = 1'b1;
    cmd(3'd1, 2'b00, 8'd5, 8'd1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL idle_abort_accept got busy=%b exp 1", busy); end
    step();
    cfg_abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL armed_abort got busy=%b exp 0", busy); end
    checks++; if (inj_count !== 8'(exp_inj)) begin errors++; $display("FAIL idle_abort_inj got %0d exp %0d", inj_count, exp_inj); end
  endtask

  task automatic test_illegal();
    cmd(3'd5, 2'b00, 8'd0, 8'd1);
    checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL illegal_lane got err=%b busy=%b exp 1/0", cfg_err, busy); end
    step();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL illegal_pulse got err=%b exp 0", cfg_err); end
    cmd(3'd1, 2'b11, 8'd0, 8'd1);
    checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL illegal_mode got err=%b busy=%b exp 1/0", cfg_err, busy); end
    sample(1'b1);
    checks++; if (lane_out !== 5'b11111 || cfg_err !== 1'b0) begin errors++; $display("FAIL illegal_after got %b err=%b exp 11111/0", lane_out, cfg_err); end
    checks++; if (inj_count !== 8'(exp_inj)) begin errors++; $display("FAIL illegal_inj got %0d exp %0d", inj_count, exp_inj); end
  endtask

  task automatic test_back_to_back();
    cmd(3'd3, 2'b01, 8'd0, 8'd1);
    sample(1'b0);
    checks++; if (lane_out !== 5'b01000 || busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL b2b_first got %b busy=%b ready=%b exp 01000/0/1", lane_out, busy, cfg_ready); end
    d_valid = 1'b1;
    d_in    = 1'b0;
    cmd(3'd1, 2'b01, 8'd0, 8'd1);
    d_valid = 1'b0;
    checks++; if (lane_out !== 5'b00000 || fault_mask !== 5'b00000 || busy !== 1'b1) begin errors++; $display("FAIL b2b_same_cycle got %b/%b busy=%b exp 00000/00000/1", lane_out, fault_mask, busy); end
    sample(1'b0);
    checks++; if (lane_out !== 5'b00010 || fault_mask !== 5'b00010 || busy !== 1'b0) begin errors++; $display("FAIL b2b_second got %b/%b busy=%b exp 00010/00010/0", lane_out, fault_mask, busy); end
    exp_inj = 5;
    checks++; if (inj_count !== 8'(exp_inj)) begin errors++; $display("FAIL b2b_inj got %0d exp %0d", inj_count, exp_inj); end
  endtask

  task automatic test_max_delay();
    int bad;
    bad = 0;
    cmd(3'd0, 2'b10, 8'd255, 8'd1);
    for (int i = 0; i < 255; i++) begin
      sample(1'b1);
      checks++; if (lane_out !== 5'b11111) begin errors++; bad++; if (bad < 4) $display("FAIL maxdly_clean[%0d] got %b exp 11111", i, lane_out); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL maxdly_busy got %b exp 1", busy); end
    sample(1'b1);
    checks++; if (lane_out !== 5'b11110 || fault_mask !== 5'b00001 || busy !== 1'b0) begin errors++; $display("FAIL maxdly_fault got %b/%b busy=%b exp 11110/00001/0", lane_out, fault_mask, busy); end
    exp_inj = 6;
  endtask

  task automatic test_reset_mid();
    cmd(3'd1, 2'b10, 8'd0, 8'd0);
    sample(1'b1);
    checks++; if (lane_out !== 5'b11101 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_active got %b busy=%b exp 11101/1", lane_out, busy); end
    d_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (lane_out !== 5'b00000 || lane_valid !== 1'b0 || fault_mask !== 5'b00000) begin errors++; $display("FAIL rstmid_outputs got %b/%b/%b exp 00000/0/00000", lane_out, lane_valid, fault_mask); end
    checks++; if (busy !== 1'b0 || cfg_err !== 1'b0 || inj_count !== 8'd0) begin errors++; $display("FAIL rstmid_status got busy=%b err=%b inj=%0d exp 0/0/0", busy, cfg_err, inj_count); end
    d_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    checks++; if (cfg_ready !== 1'b1 || busy !== 1'b0 || lane_out !== 5'b00000) begin errors++; $display("FAIL rstmid_release got ready=%b busy=%b lo=%b exp 1/0/00000", cfg_ready, busy, lane_out); end
    exp_inj = 0;
  endtask

  task automatic test_saturation();
    int bad;
    bad = 0;
    for (int e = 0; e < 260; e++) begin
      cmd(3'd0, 2'b00, 8'd0, 8'd1);
      sample(1'b1);
      if (exp_inj < 255) exp_inj++;
      checks++; if (inj_count !== 8'(exp_inj) || lane_out !== 5'b11110 || busy !== 1'b0) begin errors++; bad++; if (bad < 4) $display("FAIL sat_episode[%0d] got inj=%0d lo=%b busy=%b exp %0d/11110/0", e, inj_count, lane_out, busy, exp_inj); end
    end
    checks++; if (inj_count !== 8'd255) begin errors++; $display("FAIL sat_final got %0d exp 255", inj_count); end
  endtask

  initial begin
    rst_n = 1'b0; d_in = 1'b0; d_valid = 1'b0; cfg_valid = 1'b0; cfg_lane = 3'd0;
    cfg_mode = 2'd0; cfg_delay = 8'd0; cfg_len = 8'd0; cfg_abort = 1'b0;
    checks = 0; errors = 0; exp_inj = 0;
    test_reset();
    test_clean();
    test_window();
    test_gaps();
    test_perm_abort();
    test_idle_abort();
    test_illegal();
    test_back_to_back();
    test_max_delay();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
